// File: rtl/airi5c_dm_runctrl_pkg.sv
// Shared debug-module definitions: DMI register map,
// field positions, abstract command error codes, FSM states.
package airi5c_dm_runctrl_pkg;

  localparam logic [6:0] DM_DMCONTROL  = 7'h10;
  localparam logic [6:0] DM_DMSTATUS   = 7'h11;
  localparam logic [6:0] DM_ABSTRACTCS = 7'h16;
  localparam logic [6:0] DM_COMMAND    = 7'h17;
  localparam logic [6:0] DM_PROGBUF0   = 7'h20;
  localparam logic [6:0] DM_PROGBUF1   = 7'h21;

  localparam int DMC_HALTREQ   = 31;
  localparam int DMC_RESUMEREQ = 30;
  localparam int DMC_NDMRESET  = 1;
  localparam int DMC_DMACTIVE  = 0;

  localparam int CMD_TYPE_LO  = 24;
  localparam int CMD_POSTEXEC = 18;
  localparam int CMD_TRANSFER = 17;

  localparam int ACS_CMDERR_LO = 8;

  localparam logic [2:0] CMDERR_NONE   = 3'd0;
  localparam logic [2:0] CMDERR_BUSY   = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPT = 3'd3;
  localparam logic [2:0] CMDERR_HALT   = 3'd4;

  localparam logic [3:0] DM_VERSION  = 4'd2;
  localparam logic [4:0] PROGBUFSIZE = 5'd2;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_REQ,
    FSM_WAIT_ACK,
    FSM_RUN,
    FSM_SETTLE
  } absfsm_e;

  function automatic logic [31:0] dmstatus_word(
    input logic halted,
    input logic resack
  );
    return {14'd0, {2{resack}}, 4'd0,
            {2{~halted}}, {2{halted}},
            1'b1, 3'd0, DM_VERSION};
  endfunction

  function automatic logic [31:0] abstractcs_word(
    input logic       busy,
    input logic [2:0] cmderr
  );
    return {3'd0, PROGBUFSIZE, 11'd0, busy,
            1'b0, cmderr, 8'd0};
  endfunction

endpackage

// File: rtl/airi5c_dm_absfsm.sv
// Abstract command sequencer: validates a command and walks the
// debug ROM through a progbuf execution with timeout and settle.
module airi5c_dm_absfsm
  import airi5c_dm_runctrl_pkg::*;
#(
  parameter int EXEC_SETTLE  = 16,
  parameter int EXEC_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       i_clr,
  input  logic       i_start,
  input  logic [7:0] i_cmdtype,
  input  logic       i_transfer,
  input  logic       i_postexec,
  input  logic       i_halted,
  input  logic       i_exec_busy,
  output logic       o_busy,
  output logic       o_postexec_req,
  output logic       o_err_valid,
  output logic [2:0] o_err_code
);

  localparam int CMAX = (EXEC_TIMEOUT > EXEC_SETTLE)
                      ? EXEC_TIMEOUT : EXEC_SETTLE;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(EXEC_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(EXEC_SETTLE - 1);

  absfsm_e       r_state;
  absfsm_e       w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= FSM_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_err_valid = 1'b0;
    o_err_code  = CMDERR_NONE;
    if (i_clr) begin
      w_state_nxt = FSM_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        FSM_IDLE: begin
          if (i_start) begin
            if (!i_halted) begin
              o_err_valid = 1'b1;
              o_err_code  = CMDERR_HALT;
            end else if ((i_cmdtype != 8'd0) || i_transfer) begin
              o_err_valid = 1'b1;
              o_err_code  = CMDERR_NOTSUP;
            end else if (i_postexec) begin
              w_state_nxt = FSM_REQ;
            end
          end
        end
        FSM_REQ: begin
          w_state_nxt = FSM_WAIT_ACK;
          w_cnt_nxt   = '0;
        end
        FSM_WAIT_ACK: begin
          if (i_exec_busy) begin
            w_state_nxt = FSM_RUN;
          end else if (r_cnt == TO_LAST) begin
            o_err_valid = 1'b1;
            o_err_code  = CMDERR_EXCEPT;
            w_state_nxt = FSM_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        FSM_RUN: begin
          if (!i_halted) begin
            o_err_valid = 1'b1;
            o_err_code  = CMDERR_EXCEPT;
            w_state_nxt = FSM_IDLE;
          end else if (!i_exec_busy) begin
            w_state_nxt = FSM_SETTLE;
            w_cnt_nxt   = '0;
          end
        end
        FSM_SETTLE: begin
          // ROM needs time to run ebreak and re-enter the park loop
          if (!i_halted) begin
            o_err_valid = 1'b1;
            o_err_code  = CMDERR_EXCEPT;
            w_state_nxt = FSM_IDLE;
          end else if (r_cnt == ST_LAST) begin
            w_state_nxt = FSM_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = FSM_IDLE;
      endcase
    end
  end

  assign o_busy         = (r_state != FSM_IDLE);
  assign o_postexec_req = (r_state == FSM_REQ);

endmodule

// File: rtl/airi5c_dm_runctrl.sv
// Debug module run control: dmcontrol/dmstatus, halt/resume
// handshake, abstract command status and program buffer.
module airi5c_dm_runctrl
  import airi5c_dm_runctrl_pkg::*;
#(
  parameter int EXEC_SETTLE  = 16,
  parameter int EXEC_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        i_dmi_en,
  input  logic        i_dmi_wr,
  input  logic [6:0]  i_dmi_addr,
  input  logic [31:0] i_dmi_wdata,
  output logic [31:0] o_dmi_rdata,
  input  logic        i_halted,
  input  logic        i_resume_ack,
  input  logic        i_exec_busy,
  output logic        o_haltreq,
  output logic        o_resume_req,
  output logic        o_postexec_req,
  output logic [31:0] o_progbuf0,
  output logic [31:0] o_progbuf1,
  output logic        o_ndmreset
);

  logic        r_dmactive;
  logic        r_haltreq;
  logic        r_ndmreset;
  logic        r_resume_req;
  logic        r_resumeack;
  logic [2:0]  r_cmderr;
  logic [31:0] r_progbuf0;
  logic [31:0] r_progbuf1;
  logic [31:0] r_rdata;

  logic        w_sel_dmc;
  logic        w_sel_dms;
  logic        w_sel_acs;
  logic        w_sel_cmd;
  logic        w_sel_pb0;
  logic        w_sel_pb1;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_dmc;
  logic        w_act_nxt;
  logic        w_wr_live;
  logic        w_busy;
  logic        w_fsm_pe;
  logic        w_err_valid;
  logic [2:0]  w_err_code;
  logic        w_start;
  logic        w_busy_err;
  logic        w_resume;
  logic        w_pb_we;
  logic [2:0]  w_cmderr_nxt;
  logic [31:0] w_rdata_nxt;

  assign w_sel_dmc = (i_dmi_addr == DM_DMCONTROL);
  assign w_sel_dms = (i_dmi_addr == DM_DMSTATUS);
  assign w_sel_acs = (i_dmi_addr == DM_ABSTRACTCS);
  assign w_sel_cmd = (i_dmi_addr == DM_COMMAND);
  assign w_sel_pb0 = (i_dmi_addr == DM_PROGBUF0);
  assign w_sel_pb1 = (i_dmi_addr == DM_PROGBUF1);

  assign w_wr     = i_dmi_en & i_dmi_wr;
  assign w_rd     = i_dmi_en & ~i_dmi_wr;
  assign w_wr_dmc = w_wr & w_sel_dmc;

  // Activity after this cycle; a dmactive=0 write clears
  // everything at the very next edge.
  assign w_act_nxt = w_wr_dmc ? i_dmi_wdata[DMC_DMACTIVE]
                              : r_dmactive;
  assign w_wr_live = w_wr & r_dmactive;

  assign w_start = w_wr_live & w_sel_cmd & ~w_busy
                 & (r_cmderr == CMDERR_NONE);
  assign w_busy_err = w_wr_live & w_busy
                    & (w_sel_cmd | w_sel_pb0 | w_sel_pb1);
  assign w_pb_we = w_wr_live & ~w_busy;

  assign w_resume = w_wr_dmc & w_act_nxt
                  & i_dmi_wdata[DMC_RESUMEREQ]
                  & ~i_dmi_wdata[DMC_HALTREQ]
                  & i_halted & ~w_busy & ~r_resume_req;

  airi5c_dm_absfsm #(
    .EXEC_SETTLE  (EXEC_SETTLE),
    .EXEC_TIMEOUT (EXEC_TIMEOUT)
  ) u_absfsm (
    .clk            (clk),
    .nreset         (nreset),
    .i_clr          (~w_act_nxt),
    .i_start        (w_start),
    .i_cmdtype      (i_dmi_wdata[CMD_TYPE_LO +: 8]),
    .i_transfer     (i_dmi_wdata[CMD_TRANSFER]),
    .i_postexec     (i_dmi_wdata[CMD_POSTEXEC]),
    .i_halted       (i_halted),
    .i_exec_busy    (i_exec_busy),
    .o_busy         (w_busy),
    .o_postexec_req (w_fsm_pe),
    .o_err_valid    (w_err_valid),
    .o_err_code     (w_err_code)
  );

  always_comb begin
    w_cmderr_nxt = r_cmderr;
    if (w_wr_live & w_sel_acs) begin
      w_cmderr_nxt = r_cmderr
                   & ~i_dmi_wdata[ACS_CMDERR_LO +: 3];
    end
    if (r_cmderr == CMDERR_NONE) begin
      if (w_err_valid) begin
        w_cmderr_nxt = w_err_code;
      end else if (w_busy_err) begin
        w_cmderr_nxt = CMDERR_BUSY;
      end
    end
  end

  always_comb begin
    w_rdata_nxt = 32'd0;
    unique case (1'b1)
      w_sel_dmc: begin
        w_rdata_nxt[DMC_HALTREQ]  = r_haltreq;
        w_rdata_nxt[DMC_NDMRESET] = r_ndmreset;
        w_rdata_nxt[DMC_DMACTIVE] = r_dmactive;
      end
      w_sel_dms: w_rdata_nxt = dmstatus_word(i_halted, r_resumeack);
      w_sel_acs: w_rdata_nxt = abstractcs_word(w_busy, r_cmderr);
      w_sel_pb0: w_rdata_nxt = r_progbuf0;
      w_sel_pb1: w_rdata_nxt = r_progbuf1;
      default:   w_rdata_nxt = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rdata <= 32'd0;
    end else if (w_rd) begin
      r_rdata <= w_rdata_nxt;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_dmactive   <= 1'b0;
      r_haltreq    <= 1'b0;
      r_ndmreset   <= 1'b0;
      r_resume_req <= 1'b0;
      r_resumeack  <= 1'b0;
      r_cmderr     <= CMDERR_NONE;
      r_progbuf0   <= 32'd0;
      r_progbuf1   <= 32'd0;
    end else if (!w_act_nxt) begin
      r_dmactive   <= 1'b0;
      r_haltreq    <= 1'b0;
      r_ndmreset   <= 1'b0;
      r_resume_req <= 1'b0;
      r_resumeack  <= 1'b0;
      r_cmderr     <= CMDERR_NONE;
      r_progbuf0   <= 32'd0;
      r_progbuf1   <= 32'd0;
    end else begin
      r_dmactive <= 1'b1;
      r_cmderr   <= w_cmderr_nxt;
      if (w_wr_dmc) begin
        r_haltreq  <= i_dmi_wdata[DMC_HALTREQ];
        r_ndmreset <= i_dmi_wdata[DMC_NDMRESET];
      end
      if (w_resume) begin
        r_resume_req <= 1'b1;
        r_resumeack  <= 1'b0;
      end else if (r_resume_req & i_resume_ack) begin
        r_resume_req <= 1'b0;
        r_resumeack  <= 1'b1;
      end
      if (w_pb_we & w_sel_pb0) begin
        r_progbuf0 <= i_dmi_wdata;
      end
      if (w_pb_we & w_sel_pb1) begin
        r_progbuf1 <= i_dmi_wdata;
      end
    end
  end

  assign o_dmi_rdata    = r_rdata;
  assign o_haltreq      = r_haltreq;
  assign o_resume_req   = r_resume_req;
  assign o_postexec_req = w_fsm_pe;
  assign o_progbuf0     = r_progbuf0;
  assign o_progbuf1     = r_progbuf1;
  assign o_ndmreset     = r_ndmreset;

endmodule

// File: tb/tb_airi5c_dm_runctrl.sv
// Directed bench for airi5c_dm_runctrl: a vector table for the
// register/halt/resume behaviour plus abstract command sequences.
module tb_airi5c_dm_runctrl;

  logic        clk;
  logic        nreset;
  logic        dmi_en;
  logic        dmi_wr;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic [31:0] dmi_rdata;
  logic        halted;
  logic        resume_ack;
  logic        exec_busy;
  logic        haltreq;
  logic        resume_req;
  logic        postexec_req;
  logic [31:0] progbuf0;
  logic [31:0] progbuf1;
  logic        ndmreset;

  int n_chk = 0;
  int n_err = 0;

  airi5c_dm_runctrl #(
    .EXEC_SETTLE  (16),
    .EXEC_TIMEOUT (1024)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .i_dmi_en       (dmi_en),
    .i_dmi_wr       (dmi_wr),
    .i_dmi_addr     (dmi_addr),
    .i_dmi_wdata    (dmi_wdata),
    .o_dmi_rdata    (dmi_rdata),
    .i_halted       (halted),
    .i_resume_ack   (resume_ack),
    .i_exec_busy    (exec_busy),
    .o_haltreq      (haltreq),
    .o_resume_req   (resume_req),
    .o_postexec_req (postexec_req),
    .o_progbuf0     (progbuf0),
    .o_progbuf1     (progbuf1),
    .o_ndmreset     (ndmreset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    int          op;
    logic [6:0]  addr;
    logic [31:0] wd;
    logic        hlt;
    logic        ack;
    logic [31:0] rd;
    logic        hrq;
    logic        rrq;
    logic        nrst;
    logic [31:0] pb0;
    logic [31:0] pb1;
  } vec_t;

  vec_t tv[$];

  localparam int OP_ID = 0;
  localparam int OP_WR = 1;
  localparam int OP_RD = 2;

  function automatic vec_t mk(
    input int op, input logic [6:0] a, input logic [31:0] wd,
    input logic h, input logic ack, input logic [31:0] rd,
    input logic hrq, input logic rrq, input logic nr,
    input logic [31:0] p0, input logic [31:0] p1);
    vec_t v;
    v.op = op; v.addr = a; v.wd = wd; v.hlt = h; v.ack = ack;
    v.rd = rd; v.hrq = hrq; v.rrq = rrq; v.nrst = nr;
    v.pb0 = p0; v.pb1 = p1;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    dmi_en = 1'b1; dmi_wr = 1'b1; dmi_addr = a; dmi_wdata = d;
    @(posedge clk); #1;
    dmi_en = 1'b0; dmi_wr = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a);
    @(negedge clk);
    dmi_en = 1'b1; dmi_wr = 1'b0; dmi_addr = a;
    @(posedge clk); #1;
    dmi_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dmi_en = 1'b0; dmi_wr = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic poll_busy(output int n, input int bound);
    n = 0;
    for (int k = 0; k < bound; k++) begin
      rd(7'h16);
      if (!dmi_rdata[12]) break;
      n++;
    end
  endtask

  initial begin
    int n;
    dmi_en = 0; dmi_wr = 0; dmi_addr = '0; dmi_wdata = '0;
    halted = 0; resume_ack = 0; exec_busy = 0;
    nreset = 0;

    tv.push_back(mk(OP_RD,7'h10,0,0,0,32'h0,0,0,0,0,0));
    tv.push_back(mk(OP_WR,7'h10,32'h80000001,0,0,0,1,0,0,0,0));
    tv.push_back(mk(OP_RD,7'h10,0,0,0,32'h80000001,1,0,0,0,0));
    tv.push_back(mk(OP_RD,7'h11,0,0,0,32'h00000C82,1,0,0,0,0));
    tv.push_back(mk(OP_ID,7'h00,0,1,0,0,1,0,0,0,0));
    tv.push_back(mk(OP_RD,7'h11,0,1,0,32'h00000382,1,0,0,0,0));
    tv.push_back(mk(OP_WR,7'h10,32'h40000001,1,0,0,0,1,0,0,0));
    tv.push_back(mk(OP_ID,7'h00,0,1,0,0,0,1,0,0,0));
    tv.push_back(mk(OP_WR,7'h10,32'h40000001,1,0,0,0,1,0,0,0));
    tv.push_back(mk(OP_RD,7'h11,0,1,0,32'h00000382,0,1,0,0,0));
    tv.push_back(mk(OP_ID,7'h00,0,1,1,0,0,0,0,0,0));
    tv.push_back(mk(OP_RD,7'h11,0,1,0,32'h00030382,0,0,0,0,0));
    tv.push_back(mk(OP_WR,7'h10,32'hC0000001,1,0,0,1,0,0,0,0));
    tv.push_back(mk(OP_RD,7'h11,0,1,0,32'h00030382,1,0,0,0,0));
    tv.push_back(mk(OP_WR,7'h10,32'h40000001,0,0,0,0,0,0,0,0));
    tv.push_back(mk(OP_RD,7'h11,0,0,0,32'h00030C82,0,0,0,0,0));
    tv.push_back(mk(OP_WR,7'h10,32'h00000003,0,0,0,0,0,1,0,0));
    tv.push_back(mk(OP_RD,7'h10,0,0,0,32'h00000003,0,0,1,0,0));
    tv.push_back(mk(OP_WR,7'h20,32'hDEADBEEF,0,0,0,0,0,1,
                    32'hDEADBEEF,0));
    tv.push_back(mk(OP_WR,7'h21,32'h00100073,0,0,0,0,0,1,
                    32'hDEADBEEF,32'h00100073));
    tv.push_back(mk(OP_RD,7'h20,0,0,0,32'hDEADBEEF,0,0,1,
                    32'hDEADBEEF,32'h00100073));
    tv.push_back(mk(OP_RD,7'h21,0,0,0,32'h00100073,0,0,1,
                    32'hDEADBEEF,32'h00100073));
    tv.push_back(mk(OP_RD,7'h16,0,0,0,32'h02000000,0,0,1,
                    32'hDEADBEEF,32'h00100073));
    tv.push_back(mk(OP_WR,7'h30,32'hFFFFFFFF,0,0,0,0,0,1,
                    32'hDEADBEEF,32'h00100073));
    tv.push_back(mk(OP_RD,7'h30,0,0,0,32'h0,0,0,1,
                    32'hDEADBEEF,32'h00100073));
    tv.push_back(mk(OP_RD,7'h17,0,0,0,32'h0,0,0,1,
                    32'hDEADBEEF,32'h00100073));
    tv.push_back(mk(OP_WR,7'h10,32'h00000000,0,0,0,0,0,0,0,0));
    tv.push_back(mk(OP_WR,7'h20,32'h12345678,0,0,0,0,0,0,0,0));
    tv.push_back(mk(OP_RD,7'h11,0,0,0,32'h00000C82,0,0,0,0,0));
    tv.push_back(mk(OP_WR,7'h10,32'h00000001,0,0,0,0,0,0,0,0));
    tv.push_back(mk(OP_WR,7'h10,32'h40000000,1,0,0,0,0,0,0,0));
    tv.push_back(mk(OP_WR,7'h10,32'h00000001,1,0,0,0,0,0,0,0));

    repeat (3) @(negedge clk);
    chk("rst rdata", dmi_rdata, 32'h0);
    chk("rst outs", {27'd0, haltreq, resume_req, postexec_req,
                     ndmreset, 1'b0}, 32'h0);
    chk("rst pb0", progbuf0, 32'h0);
    chk("rst pb1", progbuf1, 32'h0);
    nreset = 1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      dmi_en     = (tv[i].op != OP_ID);
      dmi_wr     = (tv[i].op == OP_WR);
      dmi_addr   = tv[i].addr;
      dmi_wdata  = tv[i].wd;
      halted     = tv[i].hlt;
      resume_ack = tv[i].ack;
      @(posedge clk); #1;
      if (tv[i].op == OP_RD)
        chk($sformatf("v%0d rdata", i), dmi_rdata, tv[i].rd);
      chk($sformatf("v%0d outs", i),
          {28'd0, haltreq, resume_req, ndmreset, postexec_req},
          {28'd0, tv[i].hrq, tv[i].rrq, tv[i].nrst, 1'b0});
      chk($sformatf("v%0d pb0", i), progbuf0, tv[i].pb0);
      chk($sformatf("v%0d pb1", i), progbuf1, tv[i].pb1);
      dmi_en = 0; dmi_wr = 0; resume_ack = 0;
    end

    // progbuf execution with settle
    halted = 1;
    wr(7'h20, 32'h00000013);
    wr(7'h17, 32'h00040000);
    chk("pe pulse", {31'd0, postexec_req}, 32'd1);
    rd(7'h16);
    chk("pe one cycle", {31'd0, postexec_req}, 32'd0);
    chk("pe busy", dmi_rdata, 32'h02001000);
    exec_busy = 1;
    idle(5);
    exec_busy = 0;
    poll_busy(n, 64);
    chk("pe settle cycles", n, 17);
    chk("pe done", dmi_rdata, 32'h02000000);

    // exec_busy never rises
    wr(7'h17, 32'h00040000);
    poll_busy(n, 1100);
    chk("to cycles", n, 1025);
    chk("to cmderr", dmi_rdata, 32'h02000300);
    wr(7'h16, 32'h00000700);
    rd(7'h16);
    chk("to clear", dmi_rdata, 32'h02000000);

    // illegal commands
    halted = 0;
    wr(7'h17, 32'h00040000);
    rd(7'h16);
    chk("ill not halted", dmi_rdata, 32'h02000400);
    wr(7'h16, 32'h00000400);
    rd(7'h16);
    chk("ill w1c", dmi_rdata, 32'h02000000);
    halted = 1;
    wr(7'h17, 32'h00220000);
    rd(7'h16);
    chk("ill transfer", dmi_rdata, 32'h02000200);
    wr(7'h16, 32'h00000700);
    wr(7'h17, 32'h01040000);
    rd(7'h16);
    chk("ill cmdtype", dmi_rdata, 32'h02000200);
    wr(7'h16, 32'h00000700);
    wr(7'h17, 32'h00000000);
    chk("noexec pe", {31'd0, postexec_req}, 32'd0);
    rd(7'h16);
    chk("noexec done", dmi_rdata, 32'h02000000);

    // writes while busy
    wr(7'h17, 32'h00040000);
    wr(7'h17, 32'h00040000);
    chk("busy cmd pe", {31'd0, postexec_req}, 32'd0);
    wr(7'h20, 32'hAAAAAAAA);
    chk("busy pb0 kept", progbuf0, 32'h00000013);
    exec_busy = 1;
    idle(2);
    exec_busy = 0;
    poll_busy(n, 64);
    chk("busy fsm cycles", n, 17);
    chk("busy cmderr", dmi_rdata, 32'h02000100);
    wr(7'h17, 32'h00040000);
    chk("err blocks cmd", {31'd0, postexec_req}, 32'd0);
    wr(7'h16, 32'h00000100);
    rd(7'h16);
    chk("busy clear", dmi_rdata, 32'h02000000);

    // abort during RUN with resume pending
    wr(7'h10, 32'h40000001);
    chk("ab resume", {31'd0, resume_req}, 32'd1);
    wr(7'h17, 32'h00040000);
    chk("ab pe", {31'd0, postexec_req}, 32'd1);
    exec_busy = 1;
    idle(2);
    wr(7'h10, 32'h00000000);
    chk("ab outs", {29'd0, resume_req, postexec_req, haltreq},
        32'd0);
    chk("ab pb0 out", progbuf0, 32'h0);
    rd(7'h16);
    chk("ab not busy", dmi_rdata, 32'h02000000);
    rd(7'h20);
    chk("ab pb0 read", dmi_rdata, 32'h0);
    exec_busy = 0;
    wr(7'h10, 32'h00000001);
    rd(7'h10);
    chk("ab reactivate", dmi_rdata, 32'h00000001);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
